// File: rtl/alu_result_buffer.sv
// Receive buffer for the fixed-point ALU result interface: captures every valid
// result into a show-ahead FIFO, drops on full with a sticky overflow flag.
module alu_result_buffer #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] res_i,
  input  logic              valid_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [AW:0]       count_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              sat_o,
  output logic              overflow_o,
  input  logic              clr_ovf_i
);

  localparam logic [AW:0]              DEPTH_C = (AW+1)'(DEPTH);
  localparam logic signed [DATA_W-1:0] SAT_MAX = DATA_W'(127);
  localparam logic signed [DATA_W-1:0] SAT_MIN = -(DATA_W'(128));

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [AW:0]       r_count;
  logic              r_ovf;

  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic [AW:0]       w_count_nxt;
  logic              w_ovf_nxt;
  logic [DATA_W-1:0] w_head;

  assign w_full  = (r_count == DEPTH_C);
  assign w_empty = (r_count == {(AW+1){1'b0}});
  // A pop frees a slot in the same cycle, so a push into a full buffer is legal then.
  assign w_pop   = !w_empty && ready_i;
  assign w_push  = valid_i && (!w_full || w_pop);
  assign w_drop  = valid_i && w_full && !w_pop;

  // Next count and sticky overflow; a drop in the clearing cycle keeps the flag set.
  always_comb begin
    w_count_nxt = r_count;
    w_ovf_nxt   = r_ovf;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + {{AW{1'b0}}, 1'b1};
      2'b01:   w_count_nxt = r_count - {{AW{1'b0}}, 1'b1};
      default: w_count_nxt = r_count;
    endcase
    if (w_drop) begin
      w_ovf_nxt = 1'b1;
    end else if (clr_ovf_i) begin
      w_ovf_nxt = 1'b0;
    end else begin
      w_ovf_nxt = r_ovf;
    end
  end

  // Pointer, occupancy and overflow state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= {AW{1'b0}};
      r_rptr  <= {AW{1'b0}};
      r_count <= {(AW+1){1'b0}};
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + {{(AW-1){1'b0}}, 1'b1};
      end
      if (w_pop) begin
        r_rptr <= r_rptr + {{(AW-1){1'b0}}, 1'b1};
      end
      r_count <= w_count_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  // Storage array; contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= res_i;
    end
  end

  // Show-ahead read port, forced to zero when nothing is buffered.
  always_comb begin
    w_head = {DATA_W{1'b0}};
    if (!w_empty) begin
      w_head = r_mem[r_rptr];
    end else begin
      w_head = {DATA_W{1'b0}};
    end
  end

  assign data_o     = w_head;
  assign valid_o    = !w_empty;
  assign count_o    = r_count;
  assign full_o     = w_full;
  assign empty_o    = w_empty;
  assign overflow_o = r_ovf;
  assign sat_o      = !w_empty &&
                      (($signed(w_head) > SAT_MAX) || ($signed(w_head) < SAT_MIN));

endmodule

// File: tb/tb_alu_result_buffer.sv
// Randomized and directed bench for alu_result_buffer against a queue-based model.
module tb_alu_result_buffer;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] res_i = 16'd0;
  logic        valid_i = 1'b0;
  logic [15:0] data_o;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [3:0]  count_o;
  logic        full_o;
  logic        empty_o;
  logic        sat_o;
  logic        overflow_o;
  logic        clr_ovf_i = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  int m_q[$];
  bit m_ovf = 1'b0;

  alu_result_buffer #(.DEPTH(DEPTH), .DATA_W(16)) dut (
    .clk(clk), .rst(rst), .res_i(res_i), .valid_i(valid_i),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .count_o(count_o), .full_o(full_o), .empty_o(empty_o),
    .sat_o(sat_o), .overflow_o(overflow_o), .clr_ovf_i(clr_ovf_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    int exp_data;
    exp_data = (m_q.size() > 0) ? m_q[0] : 0;
    check("valid_o", int'(valid_o), int'(m_q.size() > 0));
    check("data_o", int'($signed(data_o)), exp_data);
    check("count_o", int'(count_o), m_q.size());
    check("full_o", int'(full_o), int'(m_q.size() == DEPTH));
    check("empty_o", int'(empty_o), int'(m_q.size() == 0));
    check("sat_o", int'(sat_o), int'((m_q.size() > 0) && (exp_data > 127 || exp_data < -128)));
    check("overflow_o", int'(overflow_o), int'(m_ovf));
  endtask

  // One clock: drive inputs, advance the model at the edge, compare at the falling edge.
  task automatic step(input bit v, input int d, input bit r, input bit c);
    bit pop;
    bit push;
    bit drop;
    valid_i   = v;
    res_i     = 16'(d);
    ready_i   = r;
    clr_ovf_i = c;
    @(posedge clk);
    pop  = (m_q.size() > 0) && r;
    push = v && ((m_q.size() < DEPTH) || pop);
    drop = v && (m_q.size() == DEPTH) && !pop;
    if (pop) void'(m_q.pop_front());
    if (push) m_q.push_back(int'($signed(16'(d))));
    if (drop) m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
    @(negedge clk);
    compare_all();
  endtask

  task automatic mid_reset();
    valid_i = 1'b0; ready_i = 1'b0; clr_ovf_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    m_q.delete();
    m_ovf = 1'b0;
    compare_all();
    @(negedge clk);
    rst = 1'b0;
    compare_all();
  endtask

  initial begin
    int sat_exp [4];
    int sat_val [4];
    sat_val = '{-129, 127, 128, -128};
    sat_exp = '{1, 0, 1, 0};

    #12 rst = 1'b0;
    @(negedge clk);
    compare_all();

    // Async reset mid-cycle after some traffic
    step(1'b1, 11, 1'b0, 1'b0);
    step(1'b1, 12, 1'b0, 1'b0);
    mid_reset();
    check("rst_empty", int'(empty_o), 1);
    check("rst_data", int'(data_o), 0);

    // Single result
    step(1'b1, 42, 1'b0, 1'b0);
    check("single_data", int'($signed(data_o)), 42);
    check("single_cnt", int'(count_o), 1);
    check("single_sat", int'(sat_o), 0);
    step(1'b0, 0, 1'b1, 1'b0);
    check("single_empty", int'(empty_o), 1);

    // Fill and overflow
    for (int i = 1; i <= 8; i++) step(1'b1, i, 1'b0, 1'b0);
    check("fill_full", int'(full_o), 1);
    check("fill_cnt", int'(count_o), 8);
    step(1'b1, 9, 1'b0, 1'b0);
    check("drop_ovf", int'(overflow_o), 1);
    check("drop_cnt", int'(count_o), 8);
    for (int i = 1; i <= 8; i++) begin
      check("drain_order", int'($signed(data_o)), i);
      step(1'b0, 0, 1'b1, 1'b0);
    end
    check("drain_empty", int'(empty_o), 1);
    step(1'b0, 0, 1'b0, 1'b1);
    check("clr_ovf", int'(overflow_o), 0);

    // Full with simultaneous push and pop
    for (int i = 1; i <= 8; i++) step(1'b1, i, 1'b0, 1'b0);
    step(1'b1, 100, 1'b1, 1'b0);
    check("pp_ovf", int'(overflow_o), 0);
    check("pp_cnt", int'(count_o), 8);
    check("pp_head", int'($signed(data_o)), 2);
    for (int i = 2; i <= 9; i++) begin
      check("pp_order", int'($signed(data_o)), (i == 9) ? 100 : i);
      step(1'b0, 0, 1'b1, 1'b0);
    end

    // Saturation flag
    for (int i = 0; i < 4; i++) step(1'b1, sat_val[i], 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("sat_flag", int'(sat_o), sat_exp[i]);
      step(1'b0, 0, 1'b1, 1'b0);
    end

    // Clear vs drop, then reset mid-traffic
    for (int i = 1; i <= 8; i++) step(1'b1, i, 1'b0, 1'b0);
    step(1'b1, 55, 1'b0, 1'b1);
    check("clr_vs_drop", int'(overflow_o), 1);
    for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b1, 1'b0);
    check("pre_rst_cnt", int'(count_o), 5);
    mid_reset();
    check("post_rst_cnt", int'(count_o), 0);
    step(1'b1, 7, 1'b0, 1'b0);
    check("post_rst_head", int'($signed(data_o)), 7);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      int d;
      d = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 511)) - 256
                                      : int'($signed(16'($urandom)));
      step($urandom_range(0, 9) < 7, d, $urandom_range(0, 9) < ((n / 500) % 2 == 0 ? 4 : 8),
           $urandom_range(0, 19) == 0);
      if (n == 1500) mid_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
